// File: rtl/led_cube_frame_receiver.sv
// Frames the host byte stream (SOF, fixed payload, EOF) into a double-buffered frame store.
// Optional build macro LED_CUBE_FRAME_CHECKSUM_EN adds an XOR checksum byte between payload and EOF.
module led_cube_frame_receiver #(
  parameter int          FRAME_BYTES    = 64,
  parameter logic [7:0]  SOF_BYTE       = 8'h20,
  parameter logic [7:0]  SYNC_BYTE      = 8'h30,
  parameter logic [7:0]  EOF_BYTE       = 8'h30,
  parameter logic [3:0]  STREAM_MODE    = 4'h3,
  parameter int          TIMEOUT_CYCLES = 1024,
  localparam int         ADDR_W         = $clog2(FRAME_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              readdatavalid,
  input  logic [7:0]        data_in,
  input  logic [3:0]        mode,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              stall_mode_change,
  output logic              new_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              frame_valid,
  output logic [15:0]       frame_count,
  output logic [7:0]        err_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HUNT    = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
  localparam logic [2:0] CHECK   = 3'd3;
`endif
  localparam logic [2:0] TAIL    = 3'd4;

  localparam int              TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              front_sel_q, front_sel_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic              frame_valid_q, frame_valid_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [7:0]        rd_data_q, rd_data_d;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic [7:0] mem_q [2][FRAME_BYTES];

  logic wr_en, commit, drop, in_body, mode_ok;
  logic [TO_W-1:0] to_inc;

  assign mode_ok = (mode == STREAM_MODE);
  assign to_inc  = to_cnt_q + TO_W'(1);

`ifdef LED_CUBE_FRAME_CHECKSUM_EN
  assign in_body = (state_q == PAYLOAD) || (state_q == CHECK) || (state_q == TAIL);
`else
  assign in_body = (state_q == PAYLOAD) || (state_q == TAIL);
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    wr_en      = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    if (!mode_ok) begin
      // Leaving stream mode silently abandons whatever is in the back buffer.
      state_d    = IDLE;
      byte_cnt_d = '0;
      to_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          // A SOF that equals the sync filler could never delimit a frame, so it is never honoured.
          if (readdatavalid && data_in == SOF_BYTE && SOF_BYTE != SYNC_BYTE) begin
            state_d    = PAYLOAD;
            byte_cnt_d = '0;
            to_cnt_d   = '0;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
            xor_d      = '0;
`endif
          end
        end
        PAYLOAD: begin
          if (readdatavalid) begin
            wr_en = 1'b1;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
            xor_d = xor_q ^ data_in;
`endif
            if (byte_cnt_q == LAST_ADDR) begin
              byte_cnt_d = '0;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
              state_d    = CHECK;
`else
              state_d    = TAIL;
`endif
            end else begin
              byte_cnt_d = byte_cnt_q + ADDR_W'(1);
            end
          end
        end
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
        CHECK: begin
          if (readdatavalid) begin
            if (data_in == xor_q) state_d = TAIL;
            else                  drop    = 1'b1;
          end
        end
`endif
        TAIL: begin
          if (readdatavalid) begin
            if (data_in == EOF_BYTE) commit = 1'b1;
            else                     drop   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (in_body) begin
        if (readdatavalid)                                 to_cnt_d = '0;
        else if (TIMEOUT_CYCLES != 0 && to_inc == TO_LIMIT) drop     = 1'b1;
        else                                               to_cnt_d = to_inc;
      end

      if (commit || drop) begin
        state_d    = HUNT;
        byte_cnt_d = '0;
        to_cnt_d   = '0;
      end
    end
  end

  always_comb begin
    front_sel_d   = commit ? ~front_sel_q : front_sel_q;
    frame_done_d  = commit;
    frame_err_d   = drop;
    frame_valid_d = frame_valid_q | commit;
    frame_count_d = commit ? frame_count_q + 16'd1 : frame_count_q;
    err_count_d   = (drop && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    rd_data_d     = mem_q[front_sel_q][rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      to_cnt_q      <= '0;
      front_sel_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
      rd_data_q     <= '0;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      to_cnt_q      <= to_cnt_d;
      front_sel_q   <= front_sel_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      frame_valid_q <= frame_valid_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
      rd_data_q     <= rd_data_d;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
      xor_q         <= xor_d;
`endif
    end
  end

  // Payload always lands in the buffer the scanner is not reading.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[~front_sel_q][byte_cnt_q] <= data_in;
  end

  assign rd_data           = rd_data_q;
  assign stall_mode_change = in_body;
  assign new_data          = readdatavalid && (state_q == PAYLOAD);
  assign frame_done        = frame_done_q;
  assign frame_err         = frame_err_q;
  assign frame_valid       = frame_valid_q;
  assign frame_count       = frame_count_q;
  assign err_count         = err_count_q;

endmodule

// File: tb/tb_led_cube_frame_receiver.sv
// Scoreboard bench for led_cube_frame_receiver: random framed streams against a frame-level model.
module tb_led_cube_frame_receiver;

  localparam int FB = 64;
  localparam int TO = 1024;
  localparam logic [7:0] SOF = 8'h20;
  localparam logic [7:0] EOF = 8'h30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        readdatavalid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [3:0]  mode = 4'h0;
  logic [5:0]  rd_addr = 6'd0;
  logic [7:0]  rd_data;
  logic        stall_mode_change, new_data, frame_done, frame_err, frame_valid;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  led_cube_frame_receiver dut (
    .clk(clk), .rst_n(rst_n), .readdatavalid(readdatavalid), .data_in(data_in),
    .mode(mode), .rd_addr(rd_addr), .rd_data(rd_data),
    .stall_mode_change(stall_mode_change), .new_data(new_data),
    .frame_done(frame_done), .frame_err(frame_err), .frame_valid(frame_valid),
    .frame_count(frame_count), .err_count(err_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: {is_err, count}
  logic [16:0] exp_q[$];
  logic [7:0]  nd_q[$];
  logic [7:0]  front_m [FB];
  logic [7:0]  pl_m [FB];
  int          fc_m = 0;
  int          ec_m = 0;
  logic        fv_m = 1'b0;
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // monitor: pops expectations whenever the DUT signals an event
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n) begin
      if (new_data) begin
        if (nd_q.size() == 0) check("new_data_unexpected", 32'd1, 32'd0);
        else check("new_data_byte", {24'd0, data_in}, {24'd0, nd_q.pop_front()});
      end
      if (frame_done || frame_err) begin
        if (exp_q.size() == 0) check("pulse_unexpected", {30'd0, frame_done, frame_err}, 32'd0);
        else begin
          e = exp_q.pop_front();
          if (e[16]) begin
            check("frame_err_pulse", {30'd0, frame_done, frame_err}, 32'd1);
            check("err_count", {24'd0, err_count}, {24'd0, e[7:0]});
          end else begin
            check("frame_done_pulse", {30'd0, frame_done, frame_err}, 32'd2);
            check("frame_count", {16'd0, frame_count}, {16'd0, e[15:0]});
          end
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [7:0] b);
    readdatavalid = v;
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic hunt_noise();
    logic [7:0] j;
    drive(1'b1, 8'h30);
    repeat ($urandom_range(0, 3)) begin
      j = 8'($urandom_range(0, 255));
      if (j == SOF) j = 8'h31;
      drive($urandom_range(0, 1) == 1, j);
    end
  endtask

  task automatic send_payload(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) drive(1'b0, 8'(SOF));
      nd_q.push_back(pl_m[i]);
      drive(1'b1, pl_m[i]);
    end
  endtask

  // kind 0: good, 1: bad tail, 2: bad checksum
  task automatic send_frame(input int kind);
    logic [7:0] x;
    logic [7:0] bad;
    hunt_noise();
    drive(1'b1, SOF);
    send_payload(FB);
    x = 8'h00;
    for (int i = 0; i < FB; i++) x = x ^ pl_m[i];
    if (kind == 0) begin
      fc_m++;
      fv_m = 1'b1;
      for (int i = 0; i < FB; i++) front_m[i] = pl_m[i];
      exp_q.push_back({1'b0, fc_m[15:0]});
    end else begin
      if (ec_m < 255) ec_m++;
      exp_q.push_back({1'b1, 8'h00, ec_m[7:0]});
    end
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
    drive(1'b1, (kind == 2) ? (x ^ 8'h01) : x);
    if (kind != 2) begin
`else
    begin
`endif
      bad = 8'($urandom_range(0, 255));
      if (bad == EOF) bad = 8'h55;
      drive(1'b1, (kind == 1) ? bad : EOF);
    end
    // read issued in the frame_done/frame_err cycle
    drive(1'b0, 8'h00);
    if (fv_m) check("rd_after_frame", {24'd0, rd_data}, {24'd0, front_m[rd_addr]});
    check("frame_valid", {31'd0, frame_valid}, {31'd0, fv_m});
  endtask

  task automatic check_front(input int n);
    for (int k = 0; k < n; k++) begin
      rd_addr = 6'($urandom_range(0, FB - 1));
      @(posedge clk);
      #1;
      check("rd_data", {24'd0, rd_data}, {24'd0, front_m[rd_addr]});
    end
  endtask

  initial begin
    int kind;
    for (int i = 0; i < FB; i++) front_m[i] = 8'h00;
    mode = 4'h3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_pulses", {30'd0, frame_done, frame_err}, 32'd0);
    check("rst_stall", {31'd0, stall_mode_change}, 32'd0);
    check("rst_new_data", {31'd0, new_data}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 8'h00);

    // directed: ramp payload, read address 5
    rd_addr = 6'd5;
    for (int i = 0; i < FB; i++) pl_m[i] = 8'(i);
    send_frame(0);
    check("rd_addr5", {24'd0, rd_data}, 32'd5);

    // directed: all-zero then all-ones back to back
    for (int i = 0; i < FB; i++) pl_m[i] = 8'h00;
    send_frame(0);
    for (int i = 0; i < FB; i++) pl_m[i] = 8'hFF;
    send_frame(0);
    check_front(4);

    // bad tail keeps the previous frame
    for (int i = 0; i < FB; i++) pl_m[i] = 8'($urandom_range(0, 255));
    send_frame(1);
    check_front(4);

    // timeout after 10 payload bytes
    hunt_noise();
    drive(1'b1, SOF);
    for (int i = 0; i < FB; i++) pl_m[i] = 8'($urandom_range(0, 255));
    send_payload(10);
    repeat (TO - 1) drive(1'b0, 8'h00);
    check("stall_before_timeout", {31'd0, stall_mode_change}, 32'd1);
    if (ec_m < 255) ec_m++;
    exp_q.push_back({1'b1, 8'h00, ec_m[7:0]});
    drive(1'b0, 8'h00);
    check("stall_after_timeout", {31'd0, stall_mode_change}, 32'd0);
    drive(1'b0, 8'h00);

    // mode change after 30 payload bytes
    hunt_noise();
    drive(1'b1, SOF);
    send_payload(30);
    check("stall_mid_frame", {31'd0, stall_mode_change}, 32'd1);
    mode = 4'h0;
    drive(1'b0, 8'h00);
    check("stall_mode_drop", {31'd0, stall_mode_change}, 32'd0);
    drive(1'b0, 8'h00);
    mode = 4'h3;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    check("mode_abort_fc", {16'd0, frame_count}, fc_m);
    check("mode_abort_ec", {24'd0, err_count}, ec_m);
    for (int i = 0; i < FB; i++) pl_m[i] = 8'($urandom_range(0, 255));
    send_frame(0);
    check_front(3);

    // random frames
    repeat (24) begin
      for (int i = 0; i < FB; i++) pl_m[i] = 8'($urandom_range(0, 255));
      rd_addr = 6'($urandom_range(0, FB - 1));
      kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) kind = 2;
`endif
      send_frame(kind);
      check_front(2);
    end

    // saturate err_count
    while (ec_m < 256 && err_count != 8'hFF && checks < 100000) begin
      for (int i = 0; i < FB; i++) pl_m[i] = 8'($urandom_range(0, 255));
      send_frame(1);
      if (ec_m == 255) break;
    end
    for (int i = 0; i < FB; i++) pl_m[i] = 8'($urandom_range(0, 255));
    send_frame(1);
    check("err_count_sat", {24'd0, err_count}, 32'hFF);
    check("frame_count_final", {16'd0, frame_count}, fc_m);
    check_front(3);

    // drain, bounded
    for (int c = 0; c < 20 && (exp_q.size() != 0 || nd_q.size() != 0); c++) drive(1'b0, 8'h00);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("nd_q_drained", nd_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
